// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_pkg
//  Description : Shared load/store-unit types. Holds the store-size encoding,
//                the default store buffer depth, the buffered entry layout
//                and the drain state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    // Store size as driven by the core; 2'b11 is the illegal encoding.
    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10
    } store_size_e;

    localparam int SB_DEPTH_DEFAULT = 4;

    // One buffered store, already word-aligned and lane-aligned.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  we;
    } sb_entry_t;

    // Drain state: BUSY whenever at least one entry is pending.
    typedef enum logic [0:0] {
        SB_IDLE = 1'b0,
        SB_BUSY = 1'b1
    } sb_state_e;

endpackage : lsu_pkg
`default_nettype wire

// File: rtl/store_aligner.sv
`default_nettype none
// ============================================================================
//  Module      : store_aligner
//  Description : Combinational legality check and lane alignment of a core
//                store request.
//  Ports       : size_i  - store size (BYTE/HALF/WORD, 11 illegal)
//                addr_i  - byte address
//                data_i  - right-justified store data
//                legal_o - request is naturally aligned and of a legal size
//                addr_o  - word address (bits [1:0] cleared)
//                data_o  - data replicated onto every matching lane
//                we_o    - byte enables for the addressed lanes
//  Revision    : 1.0 - initial release
// ============================================================================
module store_aligner
    import lsu_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic        legal_o,
    output logic [31:0] addr_o,
    output logic [31:0] data_o,
    output logic [3:0]  we_o
);

    always_comb begin
        legal_o = 1'b0;
        data_o  = '0;
        we_o    = '0;
        addr_o  = {addr_i[31:2], 2'b00};
        case (size_i)
            SIZE_BYTE: begin
                legal_o = 1'b1;
                data_o  = {4{data_i[7:0]}};
                we_o    = 4'b0001 << addr_i[1:0];
            end
            SIZE_HALF: begin
                legal_o = ~addr_i[0];
                data_o  = {2{data_i[15:0]}};
                we_o    = 4'b0011 << addr_i[1:0];
            end
            SIZE_WORD: begin
                legal_o = (addr_i[1:0] == 2'b00);
                data_o  = data_i;
                we_o    = 4'b1111;
            end
            default: begin
                legal_o = 1'b0;
            end
        endcase
    end

endmodule : store_aligner
`default_nettype wire

// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : store_buffer
//  Description : In-order store buffer between the core and the store unit.
//                Accepted stores are aligned, queued in a ring buffer and
//                presented one at a time from registered head outputs.
//  Ports       : clk      - clock, all state on rising edge
//                rst_i    - asynchronous active-high reset
//                req_i    - core store request (qualified by ready_o)
//                size_i   - store size
//                addr_i   - store byte address
//                data_i   - right-justified store data
//                ready_o  - buffer not full
//                error_o  - one-cycle pulse for a rejected illegal request
//                empty_o  - no pending stores
//                write_o  - head entry pending towards the store unit
//                addr_o   - head word address
//                data_o   - head lane-aligned data
//                we_o     - head byte enables
//                valid_i  - store unit completed the head entry
//  Revision    : 1.0 - initial release
// ============================================================================
module store_buffer
    import lsu_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic [1:0]  size_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic        ready_o,
    output logic        error_o,
    output logic        empty_o,
    output logic        write_o,
    output logic [31:0] addr_o,
    output logic [31:0] data_o,
    output logic [3:0]  we_o,
    input  logic        valid_i
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;

    sb_entry_t            r_mem [DEPTH];
    sb_entry_t            r_head;
    sb_entry_t            w_head_nxt;
    sb_entry_t            w_new;
    logic [c_ptr_w-1:0]   r_wptr;
    logic [c_ptr_w-1:0]   r_rptr;
    logic [c_ptr_w-1:0]   w_rptr_nxt;
    logic [c_cnt_w-1:0]   r_count;
    logic [c_cnt_w-1:0]   w_count_nxt;
    sb_state_e            r_state;
    sb_state_e            w_state_nxt;
    logic                 r_error;
    logic                 w_legal;
    logic                 w_full;
    logic                 w_push;
    logic                 w_pop;

    store_aligner u_aligner (
        .size_i  (size_i),
        .addr_i  (addr_i),
        .data_i  (data_i),
        .legal_o (w_legal),
        .addr_o  (w_new.addr),
        .data_o  (w_new.data),
        .we_o    (w_new.we)
    );

    assign w_full      = (r_count == c_cnt_w'(DEPTH));
    assign ready_o     = ~w_full;
    assign w_push      = req_i & ready_o & w_legal;
    // write_o is low while empty, so a stray valid_i cannot pop anything.
    assign w_pop       = valid_i & write_o;
    assign w_count_nxt = r_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
    assign w_rptr_nxt  = r_rptr + c_ptr_w'(w_pop);

    // Next head: the incoming entry when it lands on an otherwise empty
    // queue (including push+pop of the last entry), else the entry the read
    // pointer will point at. Without a pop this re-reads the same slot, so
    // the outputs stay stable while write_o is high.
    always_comb begin
        w_head_nxt = r_head;
        if (w_push && (r_count == c_cnt_w'(w_pop))) begin
            w_head_nxt = w_new;
        end else if (w_count_nxt != '0) begin
            w_head_nxt = r_mem[w_rptr_nxt];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            SB_IDLE: begin
                if (w_push) begin
                    w_state_nxt = SB_BUSY;
                end
            end
            SB_BUSY: begin
                if (w_pop && !w_push && (r_count == c_cnt_w'(1))) begin
                    w_state_nxt = SB_IDLE;
                end
            end
            default: begin
                w_state_nxt = SB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            r_state <= SB_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_head  <= '0;
            r_error <= 1'b0;
        end else begin
            r_wptr  <= r_wptr + c_ptr_w'(w_push);
            r_rptr  <= w_rptr_nxt;
            r_count <= w_count_nxt;
            r_head  <= w_head_nxt;
            r_error <= req_i & ready_o & ~w_legal;
        end
    end

    // Storage needs no reset: slots are only read after being written.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_new;
        end
    end

    assign write_o = (r_state == SB_BUSY);
    assign empty_o = (r_count == '0);
    assign error_o = r_error;
    assign addr_o  = r_head.addr;
    assign data_o  = r_head.data;
    assign we_o    = r_head.we;

endmodule : store_buffer
`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_store_buffer
//  Description : Self-checking bench for store_buffer. A queue-based model
//                derives the expected head entry and flags from the
//                request/size/address rules; directed scenarios are followed
//                by a randomized traffic phase.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_store_buffer;
    import lsu_pkg::*;

    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  we;
    } m_entry_t;

    logic        clk;
    logic        rst_i;
    logic        req_i;
    logic [1:0]  size_i;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic        ready_o;
    logic        error_o;
    logic        empty_o;
    logic        write_o;
    logic [31:0] addr_o;
    logic [31:0] data_o;
    logic [3:0]  we_o;
    logic        valid_i;

    m_entry_t q[$];
    bit       exp_err;
    int       n_pass;
    int       n_fail;
    int       n_total;

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst_i   (rst_i),
        .req_i   (req_i),
        .size_i  (size_i),
        .addr_i  (addr_i),
        .data_i  (data_i),
        .ready_o (ready_o),
        .error_o (error_o),
        .empty_o (empty_o),
        .write_o (write_o),
        .addr_o  (addr_o),
        .data_o  (data_o),
        .we_o    (we_o),
        .valid_i (valid_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Legal when the size is one of the three encodings and the address is
    // a multiple of the access width.
    function automatic bit m_legal(input logic [1:0] sz, input logic [31:0] a);
        int nb;
        if (sz == 2'b11) return 1'b0;
        nb = 1 << sz;
        return (a % nb) == 0;
    endfunction

    // Lane b is enabled when it lies inside [offset, offset+nbytes); its data
    // byte is source byte (b mod nbytes), which replicates narrow stores.
    function automatic m_entry_t m_align(input logic [1:0] sz, input logic [31:0] a,
                                         input logic [31:0] d);
        m_entry_t e;
        int nb;
        int off;
        nb     = 1 << sz;
        off    = int'(a % 4);
        e.addr = a - (a % 4);
        e.we   = '0;
        e.data = '0;
        for (int b = 0; b < 4; b++) begin
            e.data[8*b +: 8] = d[8*(b % nb) +: 8];
            if (b >= off && b < off + nb) e.we[b] = 1'b1;
        end
        return e;
    endfunction

    task automatic check_outputs();
        check("ready", ready_o, (q.size() < DEPTH));
        check("empty", empty_o, (q.size() == 0));
        check("write", write_o, (q.size() != 0));
        check("error", error_o, exp_err);
        if (q.size() != 0) begin
            check("head_addr", addr_o, q[0].addr);
            check("head_data", data_o, q[0].data);
            check("head_we",   we_o,   q[0].we);
        end
    endtask

    // One clock: drive at the falling edge, update the model at the rising
    // edge, compare at the next falling edge.
    task automatic step(input bit req, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] d, input bit v);
        bit rdy;
        bit lgl;
        bit do_push;
        bit do_pop;
        req_i   = req;
        size_i  = sz;
        addr_i  = a;
        data_i  = d;
        valid_i = v;
        rdy     = q.size() < DEPTH;
        lgl     = m_legal(sz, a);
        do_push = req && rdy && lgl;
        do_pop  = v && (q.size() != 0);
        @(posedge clk);
        exp_err = req && rdy && !lgl;
        if (do_pop) void'(q.pop_front());
        if (do_push) q.push_back(m_align(sz, a, d));
        @(negedge clk);
        req_i   = 1'b0;
        valid_i = 1'b0;
        check_outputs();
    endtask

    task automatic idle(input bit v);
        step(1'b0, 2'b00, 32'h0, 32'h0, v);
    endtask

    initial begin
        n_pass  = 0;
        n_fail  = 0;
        n_total = 0;
        exp_err = 1'b0;
        rst_i   = 1'b1;
        req_i   = 1'b0;
        size_i  = 2'b00;
        addr_i  = '0;
        data_i  = '0;
        valid_i = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ready", ready_o, 1'b1);
        check("rst_empty", empty_o, 1'b1);
        check("rst_write", write_o, 1'b0);
        check("rst_error", error_o, 1'b0);
        check("rst_addr",  addr_o,  32'h0);
        check("rst_data",  data_o,  32'h0);
        check("rst_we",    we_o,    4'h0);
        rst_i = 1'b0;
        idle(1'b1);

        // Word store, one-cycle latency, then drain
        step(1'b1, SIZE_WORD, 32'h1000, 32'hDEADBEEF, 1'b0);
        check("word_write", write_o, 1'b1);
        check("word_addr",  addr_o,  32'h0000_1000);
        check("word_we",    we_o,    4'b1111);
        check("word_data",  data_o,  32'hDEAD_BEEF);
        idle(1'b1);
        check("word_empty", empty_o, 1'b1);

        // Byte store on the top lane
        step(1'b1, SIZE_BYTE, 32'h2003, 32'h0000_00A5, 1'b0);
        check("byte_we",   we_o,   4'b1000);
        check("byte_data", data_o, 32'hA5A5_A5A5);
        check("byte_addr", addr_o, 32'h0000_2000);
        idle(1'b1);

        // Illegal requests: misaligned half, reserved size
        step(1'b1, SIZE_HALF, 32'h3001, 32'h1234, 1'b0);
        check("half_err",   error_o, 1'b1);
        check("half_empty", empty_o, 1'b1);
        idle(1'b0);
        check("err_pulse", error_o, 1'b0);
        step(1'b1, 2'b11, 32'h4000, 32'h1, 1'b0);
        check("size3_err", error_o, 1'b1);
        idle(1'b0);

        // Fill to full, fifth push refused, pops in order
        for (int i = 1; i <= 5; i++)
            step(1'b1, SIZE_WORD, 32'h100 + 32'(4*i), 32'(i), 1'b0);
        check("full_ready", ready_o, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            check("order", data_o, 32'(i));
            idle(1'b1);
        end
        check("drained", empty_o, 1'b1);

        // Full + push + valid -> pop only; then push+pop at count 2
        for (int i = 1; i <= 4; i++)
            step(1'b1, SIZE_WORD, 32'h200 + 32'(4*i), 32'h10 + 32'(i), 1'b0);
        step(1'b1, SIZE_WORD, 32'h300, 32'h99, 1'b1);
        check("full_pop_cnt", q.size(), 3);
        check("full_pop_rdy", ready_o, 1'b1);
        idle(1'b1);
        step(1'b1, SIZE_HALF, 32'h402, 32'hCAFE, 1'b1);
        check("pp_cnt", q.size(), 2);
        check("pp_head", data_o, 32'h14);
        idle(1'b1);
        check("pp_tail", data_o, 32'hCAFE_CAFE);
        idle(1'b1);

        // Reset with entries pending
        for (int i = 0; i < 3; i++)
            step(1'b1, SIZE_BYTE, 32'h500 + 32'(i), 32'h40 + 32'(i), 1'b0);
        rst_i = 1'b1;
        #1;
        check("mid_rst_write", write_o, 1'b0);
        check("mid_rst_empty", empty_o, 1'b1);
        check("mid_rst_ready", ready_o, 1'b1);
        check("mid_rst_we",    we_o,    4'h0);
        q.delete();
        exp_err = 1'b0;
        @(negedge clk);
        rst_i = 1'b0;
        repeat (3) idle(1'b1);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            logic [31:0] a;
            logic [1:0]  sz;
            sz = 2'($urandom_range(0, 3));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            step(1'($urandom_range(0, 1)), sz, a, $urandom,
                 ($urandom_range(0, 2) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_store_buffer
`default_nettype wire
